// File: rtl/tx_hold_fifo_pkg.sv
// Shared types and status-field layout for the XGMII TX hold FIFO.
// Status is carried opaquely; the field positions document the word format for users.
`ifndef TX_HOLD_FIFO_AWIDTH
`define TX_HOLD_FIFO_AWIDTH 4
`endif

package tx_hold_fifo_pkg;

  localparam int DATA_W   = 64;
  localparam int STATUS_W = 8;
  localparam int ENTRY_W  = DATA_W + STATUS_W;

  localparam int STATUS_SOP_BIT     = 0;
  localparam int STATUS_EOP_BIT     = 1;
  localparam int STATUS_BCNT_LSB    = 2;
  localparam int STATUS_BCNT_MSB    = 4;
  localparam int STATUS_ERR_BIT     = 5;
  localparam int STATUS_RSVD_LSB    = 6;
  localparam int STATUS_RSVD_MSB    = 7;

  typedef struct packed {
    logic [STATUS_W-1:0] status;
    logic [DATA_W-1:0]   data;
  } txhfifo_entry_t;

  function automatic txhfifo_entry_t txhfifo_pack(input logic [STATUS_W-1:0] status,
                                                  input logic [DATA_W-1:0]   data);
    txhfifo_entry_t e;
    e.status = status;
    e.data   = data;
    return e;
  endfunction

endpackage

// File: rtl/tx_hold_fifo_mem.sv
// DEPTH x 72 storage array: one synchronous write port, one combinational read port.
// Kept separate so a vendor RAM with the same port behaviour can drop in.
module tx_hold_fifo_mem
  import tx_hold_fifo_pkg::*;
#(
  parameter int AWIDTH = `TX_HOLD_FIFO_AWIDTH
) (
  input  logic                clk,
  input  logic                wen,
  input  logic [AWIDTH-1:0]   waddr,
  input  txhfifo_entry_t      wdata,
  input  logic [AWIDTH-1:0]   raddr,
  output txhfifo_entry_t      rdata
);

  localparam int DEPTH = 2 ** AWIDTH;

  txhfifo_entry_t mem_array [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) begin
      mem_array[waddr] <= wdata;
    end
  end

  assign rdata = mem_array[raddr];

endmodule

// File: rtl/tx_hold_fifo.sv
// First-word-fall-through hold FIFO between TX enqueue logic and the XGMII TX encoder.
// Occupancy counts words in the array plus the registered head stage.
module tx_hold_fifo
  import tx_hold_fifo_pkg::*;
#(
  parameter int AWIDTH              = `TX_HOLD_FIFO_AWIDTH,
  parameter int ALMOST_FULL_THRESH  = 4,
  parameter int ALMOST_EMPTY_THRESH = 7
) (
  input  logic                 clk_xgmii_tx,
  input  logic                 reset_xgmii_tx_n,
  input  logic [DATA_W-1:0]    txhfifo_wdata,
  input  logic [STATUS_W-1:0]  txhfifo_wstatus,
  input  logic                 txhfifo_wen,
  output logic                 txhfifo_wfull,
  output logic                 txhfifo_walmost_full,
  input  logic                 txhfifo_ren,
  output logic [DATA_W-1:0]    txhfifo_rdata,
  output logic [STATUS_W-1:0]  txhfifo_rstatus,
  output logic                 txhfifo_rempty,
  output logic                 txhfifo_ralmost_empty,
  output logic                 txhfifo_overflow,
  output logic                 txhfifo_underflow
);

  localparam int DEPTH = 2 ** AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_W   = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_LIMIT  = DEPTH_W - (AWIDTH+1)'(ALMOST_FULL_THRESH);
  localparam logic [AWIDTH:0] AE_LIMIT  = (AWIDTH+1)'(ALMOST_EMPTY_THRESH);

  logic [AWIDTH-1:0] wptr_reg, wptr_next;
  logic [AWIDTH-1:0] rptr_reg, rptr_next;
  logic [AWIDTH:0]   occ_reg, occ_next;
  logic [AWIDTH:0]   array_count;
  logic              head_valid_reg, head_valid_next;
  txhfifo_entry_t    head_reg, head_next;
  txhfifo_entry_t    mem_rdata;
  txhfifo_entry_t    mem_wdata;

  logic wfull_reg, walmost_full_reg, ralmost_empty_reg;
  logic overflow_reg, underflow_reg;
  logic wr_accept, rd_accept, head_load;

  assign wr_accept = txhfifo_wen && !wfull_reg;
  assign rd_accept = txhfifo_ren && head_valid_reg;

  // Words still sitting in the array; a same-cycle write is not counted, so it never bypasses.
  assign array_count = occ_reg - {{AWIDTH{1'b0}}, head_valid_reg};
  assign head_load   = (array_count != '0) && (!head_valid_reg || rd_accept);

  assign mem_wdata = txhfifo_pack(txhfifo_wstatus, txhfifo_wdata);

  tx_hold_fifo_mem #(
    .AWIDTH (AWIDTH)
  ) u_mem (
    .clk   (clk_xgmii_tx),
    .wen   (wr_accept),
    .waddr (wptr_reg),
    .wdata (mem_wdata),
    .raddr (rptr_reg),
    .rdata (mem_rdata)
  );

  always_comb begin
    wptr_next       = wptr_reg;
    rptr_next       = rptr_reg;
    occ_next        = occ_reg;
    head_next       = head_reg;
    head_valid_next = head_valid_reg;

    if (wr_accept) begin
      wptr_next = wptr_reg + AWIDTH'(1);
    end

    if (wr_accept && !rd_accept) begin
      occ_next = occ_reg + (AWIDTH+1)'(1);
    end else if (rd_accept && !wr_accept) begin
      occ_next = occ_reg - (AWIDTH+1)'(1);
    end

    if (head_load) begin
      head_next       = mem_rdata;
      head_valid_next = 1'b1;
      rptr_next       = rptr_reg + AWIDTH'(1);
    end else if (rd_accept) begin
      head_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
    if (!reset_xgmii_tx_n) begin
      wptr_reg          <= '0;
      rptr_reg          <= '0;
      occ_reg           <= '0;
      head_reg          <= '0;
      head_valid_reg    <= 1'b0;
      wfull_reg         <= 1'b0;
      walmost_full_reg  <= 1'b0;
      ralmost_empty_reg <= 1'b1;
      overflow_reg      <= 1'b0;
      underflow_reg     <= 1'b0;
    end else begin
      wptr_reg          <= wptr_next;
      rptr_reg          <= rptr_next;
      occ_reg           <= occ_next;
      head_reg          <= head_next;
      head_valid_reg    <= head_valid_next;
      wfull_reg         <= (occ_next == DEPTH_W);
      walmost_full_reg  <= (occ_next >= AF_LIMIT);
      ralmost_empty_reg <= (occ_next <= AE_LIMIT);
      overflow_reg      <= txhfifo_wen && wfull_reg;
      underflow_reg     <= txhfifo_ren && !head_valid_reg;
    end
  end

  assign txhfifo_wfull         = wfull_reg;
  assign txhfifo_walmost_full  = walmost_full_reg;
  assign txhfifo_ralmost_empty = ralmost_empty_reg;
  assign txhfifo_rempty        = !head_valid_reg;
  assign txhfifo_rdata         = head_reg.data;
  assign txhfifo_rstatus       = head_reg.status;
  assign txhfifo_overflow      = overflow_reg;
  assign txhfifo_underflow     = underflow_reg;

endmodule

// File: tb/tb_tx_hold_fifo.sv
// Directed bench for tx_hold_fifo (AWIDTH = 4): reset, fall-through, fill, streaming,
// thresholds and asynchronous reset with stored contents.
module tb_tx_hold_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] wdata = '0;
  logic [7:0]  wstatus = '0;
  logic        wen = 1'b0;
  logic        ren = 1'b0;
  logic        wfull, walmost_full, rempty, ralmost_empty, overflow, underflow;
  logic [63:0] rdata;
  logic [7:0]  rstatus;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tx_hold_fifo #(
    .AWIDTH              (4),
    .ALMOST_FULL_THRESH  (4),
    .ALMOST_EMPTY_THRESH (7)
  ) dut (
    .clk_xgmii_tx          (clk),
    .reset_xgmii_tx_n      (rst_n),
    .txhfifo_wdata         (wdata),
    .txhfifo_wstatus       (wstatus),
    .txhfifo_wen           (wen),
    .txhfifo_wfull         (wfull),
    .txhfifo_walmost_full  (walmost_full),
    .txhfifo_ren           (ren),
    .txhfifo_rdata         (rdata),
    .txhfifo_rstatus       (rstatus),
    .txhfifo_rempty        (rempty),
    .txhfifo_ralmost_empty (ralmost_empty),
    .txhfifo_overflow      (overflow),
    .txhfifo_underflow     (underflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [63:0] d, input logic [7:0] s);
    wdata   = d;
    wstatus = s;
    wen     = 1'b1;
    tick();
    wen     = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rempty"},        64'(rempty),        64'd1);
    chk({tag, "_ralmost_empty"}, 64'(ralmost_empty), 64'd1);
    chk({tag, "_wfull"},         64'(wfull),         64'd0);
    chk({tag, "_walmost_full"},  64'(walmost_full),  64'd0);
    chk({tag, "_rdata"},         rdata,              64'd0);
    chk({tag, "_rstatus"},       64'(rstatus),       64'd0);
    chk({tag, "_ovf_unf"},       64'({overflow, underflow}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset / idle
    #2 rst_n = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk_reset_outputs("idle");
    $display("step reset/idle done");

    ren = 1'b1;
    tick();
    ren = 1'b0;
    chk("underflow_pulse", 64'(underflow), 64'd1);
    tick();
    chk("underflow_clear", 64'(underflow), 64'd0);
    $display("step underflow pulse done");

    // Fall-through: visible one edge after the accepting edge
    write_word(64'h0123456789ABCDEF, 8'h01);
    chk("ft_empty_after_N", 64'(rempty), 64'd1);
    tick();
    chk("ft_rempty", 64'(rempty), 64'd0);
    chk("ft_rdata", rdata, 64'h0123456789ABCDEF);
    chk("ft_rstatus", 64'(rstatus), 64'h01);
    ren = 1'b1;
    tick();
    ren = 1'b0;
    chk("ft_pop_empty", 64'(rempty), 64'd1);
    chk("ft_pop_no_unf", 64'(underflow), 64'd0);
    $display("step fall-through done");

    // Fill to full
    for (int i = 1; i <= 16; i++) begin
      write_word(64'h1000 + 64'(i), 8'(i));
      chk($sformatf("fill%0d_almost_full", i), 64'(walmost_full), 64'(i >= 12));
      chk($sformatf("fill%0d_wfull", i), 64'(wfull), 64'(i >= 16));
    end
    write_word(64'hDEAD_BEEF, 8'hFF);
    chk("ovf_pulse", 64'(overflow), 64'd1);
    chk("ovf_still_full", 64'(wfull), 64'd1);
    tick();
    chk("ovf_clear", 64'(overflow), 64'd0);
    $display("step fill done");

    ren = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("drain%0d_rempty", i), 64'(rempty), 64'd0);
      chk($sformatf("drain%0d_rdata", i), rdata, 64'h1000 + 64'(i));
      chk($sformatf("drain%0d_rstatus", i), 64'(rstatus), 64'(i));
      tick();
    end
    ren = 1'b0;
    chk("drain_empty", 64'(rempty), 64'd1);
    chk("drain_not_full", 64'(wfull), 64'd0);
    chk("drain_almost_empty", 64'(ralmost_empty), 64'd1);
    chk("drain_no_unf", 64'(underflow), 64'd0);
    $display("step drain done");

    // Streaming: prime two words, then 40 cycles of concurrent write and read
    write_word(64'hA000, 8'h00);
    write_word(64'hA001, 8'h01);
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("stream%0d_rdata", k), rdata, 64'hA000 + 64'(k));
      wdata   = 64'hA000 + 64'(k + 2);
      wstatus = 8'(k + 2);
      wen     = 1'b1;
      ren     = 1'b1;
      tick();
      chk($sformatf("stream%0d_ovf_unf", k), 64'({overflow, underflow}), 64'd0);
    end
    wen = 1'b0;
    chk("stream_flags", 64'({wfull, walmost_full, ralmost_empty}), 64'b001);
    for (int k = 40; k < 42; k++) begin
      chk($sformatf("stream_tail%0d", k), rdata, 64'hA000 + 64'(k));
      tick();
    end
    ren = 1'b0;
    chk("stream_end_empty", 64'(rempty), 64'd1);
    $display("step streaming done");

    // Almost-empty threshold
    for (int i = 0; i < 8; i++) begin
      write_word(64'hB000 + 64'(i), 8'h10);
      chk($sformatf("thr_fill%0d_almost_empty", i + 1), 64'(ralmost_empty), 64'(i < 7));
    end
    ren = 1'b1;
    tick();
    ren = 1'b0;
    chk("thr_pop_almost_empty", 64'(ralmost_empty), 64'd1);
    chk("thr_pop_rdata", rdata, 64'hB001);
    ren = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    ren = 1'b0;
    chk("thr_end_empty", 64'(rempty), 64'd1);
    $display("step thresholds done");

    // Asynchronous reset with contents stored
    for (int i = 0; i < 10; i++) write_word(64'hC000 + 64'(i), 8'h20);
    chk("mid_not_empty", 64'(rempty), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_async");
    #1 rst_n = 1'b1;
    tick();
    chk("mid_still_empty", 64'(rempty), 64'd1);
    write_word(64'hC0DE_0001, 8'h03);
    chk("mid_wr_after_N", 64'(rempty), 64'd1);
    tick();
    chk("mid_wr_rempty", 64'(rempty), 64'd0);
    chk("mid_wr_rdata", rdata, 64'hC0DE_0001);
    chk("mid_wr_rstatus", 64'(rstatus), 64'h03);
    $display("step reset mid-operation done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
